// File: rtl/fp32_addsub_arbiter_if.sv
// Requester/consumer bundle for fp32_addsub_arbiter: packed per-requester operation requests
// plus the tagged response stream. The master is the requester/consumer side, the slave is the arbiter.
interface fp32_addsub_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
);
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*32-1:0] req_a;
   logic [NUM_REQ*32-1:0] req_b;
   logic [NUM_REQ-1:0]    req_cmd;
   logic                  resp_valid;
   logic                  resp_ready;
   logic [31:0]           resp_data;
   logic [ID_W-1:0]       resp_id;

   modport master (
      output req_valid, req_a, req_b, req_cmd, resp_ready,
      input  req_ready, resp_valid, resp_data, resp_id
   );
   modport slave (
      input  req_valid, req_a, req_b, req_cmd, resp_ready,
      output req_ready, resp_valid, resp_data, resp_id
   );
endinterface

// File: rtl/fp32_addsub_arbiter.sv
// Round-robin sharing of one fp32 add/sub unit among NUM_REQ requesters, with a credit-protected
// tagged response FIFO. Define FP32_ARB_OPCNT_EN to add the saturating op_count output.
module fp32_addsub_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int LATENCY    = 1,
   parameter int RESP_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   fp32_addsub_arbiter_if.slave        bus,
   output logic [31:0]                 fpu_add1,
   output logic [31:0]                 fpu_add2,
   output logic                        fpu_command,
   input  logic [31:0]                 fpu_result,
`ifdef FP32_ARB_OPCNT_EN
   output logic [15:0]                 op_count,
`endif
   output logic                        busy
);
   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
   localparam int CNT_W = $clog2(RESP_DEPTH + 1);

   logic [ID_W-1:0]                  rr_ptr_q, rr_ptr_d;
   logic [LATENCY-1:0]               pv_q;
   logic [LATENCY-1:0][ID_W-1:0]     pid_q;
   logic [RESP_DEPTH-1:0][31:0]      mem_q;
   logic [RESP_DEPTH-1:0][ID_W-1:0]  mid_q;
   logic [PTR_W-1:0]                 wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]                 cnt_q, cnt_d;
   logic [NUM_REQ-1:0][31:0]         a_arr, b_arr;
   logic [ID_W-1:0]                  gnt_id;
   logic                             gnt_found, can_issue, fire, push, pop;
   int unsigned                      occ;

   assign a_arr = bus.req_a;
   assign b_arr = bus.req_b;

   // Credits cover both in-flight ops and stored results, so the FIFO can never overflow.
   always_comb begin
      occ = 32'(cnt_q);
      for (int s = 0; s < LATENCY; s++) occ += 32'(pv_q[s]);
   end

   assign can_issue = !rst && (occ < 32'(RESP_DEPTH));
   assign busy      = (occ != 0);

   always_comb begin
      logic [ID_W-1:0] idx;
      gnt_found = 1'b0;
      gnt_id    = '0;
      idx       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!gnt_found && bus.req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = idx;
         end
      end
   end

   assign fire = can_issue && gnt_found;

   always_comb begin
      bus.req_ready = '0;
      if (fire) bus.req_ready[gnt_id] = 1'b1;
   end

   assign fpu_add1    = fire ? a_arr[gnt_id]       : '0;
   assign fpu_add2    = fire ? b_arr[gnt_id]       : '0;
   assign fpu_command = fire ? bus.req_cmd[gnt_id] : 1'b0;
   assign rr_ptr_d    = (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;

   assign push  = pv_q[LATENCY-1];
   assign pop   = bus.resp_valid && bus.resp_ready;
   assign cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);

   assign bus.resp_valid = (cnt_q != '0);
   assign bus.resp_data  = bus.resp_valid ? mem_q[rd_ptr_q] : '0;
   assign bus.resp_id    = bus.resp_valid ? mid_q[rd_ptr_q] : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q <= '0;
         pv_q     <= '0;
         pid_q    <= '0;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (fire) rr_ptr_q <= rr_ptr_d;
         pv_q[0]  <= fire;
         pid_q[0] <= gnt_id;
         for (int s = 1; s < LATENCY; s++) begin
            pv_q[s]  <= pv_q[s-1];
            pid_q[s] <= pid_q[s-1];
         end
         if (push) wr_ptr_q <= (wr_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_q <= (rd_ptr_q == PTR_W'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
         cnt_q <= cnt_d;
      end
   end

   // Storage needs no reset: the head is gated by the count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= fpu_result;
         mid_q[wr_ptr_q] <= pid_q[LATENCY-1];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) assert (!(push && cnt_q == CNT_W'(RESP_DEPTH)));
   end

`ifdef FP32_ARB_OPCNT_EN
   logic [15:0] op_cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                              op_cnt_q <= '0;
      else if (fire && op_cnt_q != 16'hFFFF) op_cnt_q <= op_cnt_q + 16'd1;
   end
   assign op_count = op_cnt_q;
`endif
endmodule

// File: tb/tb_fp32_addsub_arbiter.sv
// Bench for fp32_addsub_arbiter: a stub fp32 unit plus a queue-based reference model of the
// arbiter/credit/FIFO behaviour, compared against the DUT every cycle on the falling edge.
module tb_fp32_addsub_arbiter;
   localparam int NR = 4, LAT = 1, DEPTH = 4;

   logic clk = 1'b0, rst = 1'b1, busy, fpu_command;
   logic [31:0] fpu_add1, fpu_add2, fpu_result;
`ifdef FP32_ARB_OPCNT_EN
   logic [15:0] op_count;
`endif
   always #5 clk = ~clk;

   fp32_addsub_arbiter_if #(.NUM_REQ(NR)) bus ();

   fp32_addsub_arbiter #(.NUM_REQ(NR), .LATENCY(LAT), .RESP_DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .bus(bus),
      .fpu_add1(fpu_add1), .fpu_add2(fpu_add2), .fpu_command(fpu_command),
      .fpu_result(fpu_result),
`ifdef FP32_ARB_OPCNT_EN
      .op_count(op_count),
`endif
      .busy(busy)
   );

   function automatic real fp2r(input logic [31:0] f);
      logic [63:0] d;
      if (f[30:0] == 31'd0) return 0.0;
      d = {f[31], 11'(f[30:23]) - 11'd127 + 11'd1023, f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] r2fp(input real r);
      logic [63:0] d;
      d = $realtobits(r);
      if (d[62:0] == 63'd0) return {d[63], 31'd0};
      return {d[63], 8'(d[62:52] - 11'd1023 + 11'd127), d[51:29]};
   endfunction

   function automatic logic [31:0] fp_op(input logic [31:0] a, input logic [31:0] b, input logic c);
      return r2fp(c ? fp2r(a) + fp2r(b) : fp2r(a) - fp2r(b));
   endfunction

   // Stub of the shared unit: combinational inputs, result registered LAT cycles later.
   logic [31:0] fpu_pipe [LAT];
   always @(posedge clk) begin
      fpu_pipe[0] <= fp_op(fpu_add1, fpu_add2, fpu_command);
      for (int s = 1; s < LAT; s++) fpu_pipe[s] <= fpu_pipe[s-1];
   end
   assign fpu_result = fpu_pipe[LAT-1];

   typedef struct { int id; logic [31:0] data; int rem; } ent_t;
   ent_t infl[$];
   ent_t fq[$];
   int rr = 0, last_gnt = -1, errors = 0, checks = 0;
   logic [31:0] op_a [NR], op_b [NR];
   logic        op_c [NR], v [NR];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      logic [NR-1:0][31:0] pa, pb;
      for (int i = 0; i < NR; i++) begin
         pa[i] = op_a[i]; pb[i] = op_b[i];
         bus.req_valid[i] = v[i]; bus.req_cmd[i] = op_c[i];
      end
      bus.req_a = pa; bus.req_b = pb;
   endtask

   task automatic new_op(input int i);
      op_a[i] = r2fp(real'(int'($urandom_range(2000)) - 1000));
      op_b[i] = r2fp(real'(int'($urandom_range(2000)) - 1000));
      op_c[i] = 1'($urandom_range(1));
   endtask

   // Compare the DUT with the model for the current cycle, then advance the model past the next edge.
   task automatic step();
      int occ, g;
      logic [NR-1:0] er;
      ent_t e;
      if (rst) begin
         chk("rst_req_ready", 32'(bus.req_ready), 0);
         chk("rst_resp_valid", 32'(bus.resp_valid), 0);
         chk("rst_resp_data", bus.resp_data, 0);
         chk("rst_resp_id", 32'(bus.resp_id), 0);
         chk("rst_busy", 32'(busy), 0);
         chk("rst_fpu", fpu_add1 | fpu_add2 | 32'(fpu_command), 0);
         infl.delete(); fq.delete(); rr = 0; last_gnt = -1;
         return;
      end
      occ = infl.size() + fq.size();
      g = -1;
      if (occ < DEPTH)
         for (int k = 0; k < NR; k++)
            if (g < 0 && v[(rr + k) % NR]) g = (rr + k) % NR;
      er = '0;
      if (g >= 0) er[g] = 1'b1;
      chk("req_ready", 32'(bus.req_ready), 32'(er));
      chk("fpu_add1", fpu_add1, g >= 0 ? op_a[g] : 32'd0);
      chk("fpu_add2", fpu_add2, g >= 0 ? op_b[g] : 32'd0);
      chk("fpu_command", 32'(fpu_command), g >= 0 ? 32'(op_c[g]) : 32'd0);
      chk("busy", 32'(busy), 32'(occ != 0));
      chk("resp_valid", 32'(bus.resp_valid), 32'(fq.size() != 0));
      if (fq.size() != 0) begin
         chk("resp_data", bus.resp_data, fq[0].data);
         chk("resp_id", 32'(bus.resp_id), 32'(fq[0].id));
         if (bus.resp_ready) void'(fq.pop_front());
      end
      for (int s = 0; s < infl.size(); s++) infl[s].rem = infl[s].rem - 1;
      while (infl.size() > 0 && infl[0].rem == 0) fq.push_back(infl.pop_front());
      if (g >= 0) begin
         e.id = g; e.data = fp_op(op_a[g], op_b[g], op_c[g]); e.rem = LAT;
         infl.push_back(e);
         rr = (g + 1) % NR;
      end
      last_gnt = g;
   endtask

   task automatic tick();
      @(negedge clk);
      step();
      @(posedge clk);
      #2;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < NR; i++) v[i] = 1'b0;
      bus.resp_ready = 1'b1;
      drive();
      for (int c = 0; c < 50 && busy; c++) tick();
      chk(name, 32'(busy), 0);
   endtask

   int gseq [8];
   int fires, f1, f2, f3;

   initial begin
      for (int i = 0; i < NR; i++) begin
         v[i] = 1'b0; op_a[i] = '0; op_b[i] = '0; op_c[i] = 1'b0;
      end
      bus.resp_ready = 1'b0;
      drive();
      tick(); tick();
      rst = 1'b0;
      tick();

      // Round robin with every requester asserting.
      bus.resp_ready = 1'b1;
      for (int i = 0; i < NR; i++) begin new_op(i); v[i] = 1'b1; end
      drive();
      for (int c = 0; c < 8; c++) begin
         tick();
         gseq[c] = last_gnt;
         if (last_gnt >= 0) new_op(last_gnt);
         drive();
      end
      for (int c = 0; c < 8; c++) chk("rr_order", 32'(gseq[c]), 32'(c % NR));
      drain("rr_drain");

      // Single add from requester 0: 1.0 + 2.0.
      op_a[0] = 32'h3F800000; op_b[0] = 32'h40000000; op_c[0] = 1'b1; v[0] = 1'b1;
      drive();
      #1 chk("add_ready", 32'(bus.req_ready), 32'h1);
      tick();
      v[0] = 1'b0; drive();
      tick();
      chk("add_resp_valid", 32'(bus.resp_valid), 1);
      chk("add_resp_data", bus.resp_data, 32'h40400000);
      chk("add_resp_id", 32'(bus.resp_id), 0);
      tick();

      // Single sub from requester 2: 3.0 - 1.0.
      op_a[2] = 32'h40400000; op_b[2] = 32'h3F800000; op_c[2] = 1'b0; v[2] = 1'b1;
      drive();
      tick();
      v[2] = 1'b0; drive();
      tick();
      chk("sub_resp_data", bus.resp_data, 32'h40000000);
      chk("sub_resp_id", 32'(bus.resp_id), 2);
      drain("sub_drain");

      // Backpressure: credits run out after DEPTH fires.
      bus.resp_ready = 1'b0;
      new_op(0); new_op(1); v[0] = 1'b1; v[1] = 1'b1;
      drive();
      fires = 0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (last_gnt >= 0) begin fires++; new_op(last_gnt); end
         drive();
      end
      chk("bp_fires", 32'(fires), DEPTH);
      chk("bp_ready_zero", 32'(bus.req_ready), 0);
      bus.resp_ready = 1'b1; drive();
      tick(); f1 = last_gnt;
      if (last_gnt >= 0) new_op(last_gnt);
      bus.resp_ready = 1'b0; drive();
      tick(); f2 = last_gnt;
      if (last_gnt >= 0) new_op(last_gnt);
      drive();
      tick(); f3 = last_gnt;
      chk("bp_pop_cycle_fire", 32'(f1 >= 0), 0);
      chk("bp_next_cycle_fire", 32'(f2 >= 0), 1);
      chk("bp_after_fire", 32'(f3 >= 0), 0);
      drain("bp_drain");

      // Async reset with one op in flight and two results stored.
      bus.resp_ready = 1'b0;
      new_op(1); v[1] = 1'b1; drive();
      fires = 0;
      for (int c = 0; c < 10 && fires < 3; c++) begin
         tick();
         if (last_gnt >= 0) begin fires++; new_op(last_gnt); drive(); end
      end
      chk("ar_setup_fires", 32'(fires), 3);
      for (int i = 0; i < NR; i++) v[i] = 1'b1;
      drive();
      rst = 1'b1;
      #1;
      chk("ar_req_ready", 32'(bus.req_ready), 0);
      chk("ar_resp_valid", 32'(bus.resp_valid), 0);
      chk("ar_busy", 32'(busy), 0);
      tick();
      rst = 1'b0;
      #1 chk("ar_first_grant", 32'(bus.req_ready), 32'h1);
      bus.resp_ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (last_gnt >= 0) new_op(last_gnt);
         drive();
      end
      drain("ar_drain");

      // Randomized traffic with random consumer backpressure.
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (!v[i] || last_gnt == i) begin
               new_op(i);
               v[i] = ($urandom_range(99) < 60);
            end else if ($urandom_range(99) < 3) begin
               v[i] = 1'b0;
            end
         end
         bus.resp_ready = ($urandom_range(99) < 70);
         drive();
         tick();
      end
      drain("rand_drain");

`ifdef FP32_ARB_OPCNT_EN
      rst = 1'b1; tick(); rst = 1'b0;
      v[3] = 1'b1; new_op(3); drive();
      fires = 0;
      for (int c = 0; c < 20 && fires < 5; c++) begin
         tick();
         if (last_gnt >= 0) begin
            fires++; new_op(last_gnt);
            if (fires == 5) v[3] = 1'b0;
            drive();
         end
      end
      #1 chk("opcnt_five", 32'(op_count), 5);
      drain("opcnt_drain");
      force dut.op_cnt_q = 16'hFFFF;
      #1 release dut.op_cnt_q;
      v[3] = 1'b1; drive();
      tick();
      v[3] = 1'b0; drive();
      chk("opcnt_sat", 32'(op_count), 32'hFFFF);
      drain("opcnt_sat_drain");
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/fp32_addsub_arbiter.md
Name: fp32_addsub_arbiter

Overview:
- Shares one fp32 add/sub unit among NUM_REQ requesters using round-robin arbitration.
- The shared unit is the FP_32_add_or_sub datapath. It takes inputs combinationally and registers its result LATENCY cycles later.
- The arbiter issues at most one operation per cycle and tracks in-flight operations with a valid/id pipe.
- Results are buffered in a credit-protected response FIFO and returned tagged with the requester id. No result is ever dropped under backpressure.

Parameters:
- NUM_REQ, 4: number of requesters (2..8). ID_W = clog2(NUM_REQ) is derived internally.
- LATENCY, 1: cycles from the issue edge until fpu_result is valid (1..4).
- RESP_DEPTH, 4: response FIFO entries; must be >= LATENCY+1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- req_valid  in  NUM_REQ  per-requester operation request
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
- req_a  in  NUM_REQ*32  operand A; requester i occupies bits [32i+31:32i]
- req_b  in  NUM_REQ*32  operand B; same packing as req_a
- req_cmd  in  NUM_REQ  1=add, 0=sub
- fpu_add1  out  32  to unit operand 1
- fpu_add2  out  32  to unit operand 2
- fpu_command  out  1  to unit command
- fpu_result  in  32  from unit result
- resp_valid  out  1  response FIFO head valid
- resp_ready  in  1  consumer accepts the head
- resp_data  out  32  result at the head
- resp_id  out  ID_W  requester index of the head
- busy  out  1  high while any operation is in flight or the FIFO is non-empty

Behaviour:
- Reset (async, rst=1) clears:
  - rr_ptr to 0.
  - In-flight pipe valids to 0.
  - FIFO pointers and count to 0.
- Outputs during and after reset: req_ready=0, resp_valid=0, resp_data=0, resp_id=0, busy=0, fpu_add1=0, fpu_add2=0, fpu_command=0.
- Reset mid-operation: in-flight operations are discarded. Unit results arriving after reset are ignored because the pipe valids are cleared.
- Credit rule:
  - occ = fifo_count + number of valid pipe stages.
  - can_issue = (occ < RESP_DEPTH).
  - A FIFO pop frees its credit only from the next cycle; credits are not used in the cycle they are popped.
- Arbitration:
  - When can_issue=1, grant the first i with req_valid[i]=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready is combinational from req_valid, rr_ptr and can_issue.
  - When can_issue=0, req_ready=0.
- Issue handshake:
  - Fires on req_valid[i] & req_ready[i]; at most one fire per cycle.
  - During the fire cycle, fpu_add1/add2/command are combinationally muxed from the granted requester. When no fire occurs they drive 0.
  - On a fire, rr_ptr <= (i+1) mod NUM_REQ. Otherwise rr_ptr holds.
- In-flight pipe:
  - LATENCY-stage shift register of {valid, id}. Stage 0 loads {fire, granted id} at each edge.
  - When the last stage is valid, fpu_result is pushed into the FIFO together with that id at the next edge.
  - Total latency: fire at edge t, FIFO push at edge t+LATENCY, resp_valid high in the cycle after edge t+LATENCY.
  - With LATENCY=1, the minimum request-to-response delay is 2 cycles.
- Response FIFO:
  - Registered head; not fall-through.
  - Pop on resp_valid & resp_ready.
  - Push and pop in the same cycle are both performed.
  - Overflow is impossible by the credit rule; an assertion checks push while full.
  - resp_data and resp_id hold while resp_valid=1 and resp_ready=0.
- Requesters must hold operands while req_valid=1 and req_ready=0. Withdrawing a request before grant is allowed.
- busy = (occ != 0).

Optional Feature:
- FP32_ARB_OPCNT_EN, when defined:
  - Adds output op_count (16 bits).
  - op_count is a saturating count of issue fires; it sticks at 0xFFFF and is reset to 0 by rst.
- When not defined: the port and the counter are absent; all other behaviour is identical.

Test Plan:
- Single add: req_valid[0]=1, A=0x3F800000, B=0x40000000, cmd=1, resp_ready=1.
  - -> req_ready[0]=1 in the same cycle.
  - -> 2 cycles later: resp_valid=1, resp_data=0x40400000, resp_id=0.
- Single sub: requester 2, A=0x40400000, B=0x3F800000, cmd=0.
  - -> resp_data=0x40000000, resp_id=2.
- Round-robin: all 4 requesters held valid for 8 cycles, resp_ready=1.
  - -> grant order 0,1,2,3,0,1,2,3.
  - -> responses return in the same id order.
  - -> no requester is granted twice before all others have been granted once.
- Backpressure: resp_ready=0, requesters 0 and 1 continuously valid, RESP_DEPTH=4.
  - -> exactly 4 fires, then req_ready=0.
  - -> raising resp_ready for one cycle allows exactly one new fire on the following cycle.
  - -> no result is lost or duplicated.
- Async reset: assert rst mid-cycle with 1 operation in flight and 2 FIFO entries.
  - -> resp_valid=0, busy=0 and req_ready=0 immediately.
  - -> after release, the first grant goes to requester 0; the stale unit result is never emitted.
- FP32_ARB_OPCNT_EN defined: 5 fires.
  - -> op_count=5.
  - -> after a forced 0xFFFF preload plus one more fire, op_count remains 0xFFFF.
